// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register address width, data width and the
// hard-wired zero register. Used by the register file, the write-register
// mux and the decoder so all three agree on these values.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_DEPTH  = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // True when an address names the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return (a == ZERO_REG);
    endfunction

endpackage : cpu_pkg

// File: rtl/regfile_array.sv
// Register file storage: one synchronous write port and two asynchronous
// read ports. Register 0 is never written and always reads as zero.
// The whole array clears on asynchronous reset.
module regfile_array
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W,
    parameter int AW = cpu_pkg::REG_ADDR_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [DEPTH-1:0][DW-1:0] mem_d;
    logic                     wr_hit;

    // Next-state of the array: only a nonzero destination is written.
    always_comb begin
        mem_d  = mem_q;
        wr_hit = we && (waddr != ZERO_A);
        if (wr_hit) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage flops, cleared by asynchronous reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read ports; entry 0 is masked even though it is never
    // written, so the zero register cannot leak a value by construction.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != ZERO_A) begin
            rdata1 = mem_q[raddr1];
        end
        if (raddr2 != ZERO_A) begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule : regfile_array

// File: rtl/reg_file_reader.sv
// Read side of the CPU register file: storage array plus two registered
// read ports (A/B operand registers) feeding the ALU-operand stage.
// A read request captures reg[rs]/reg[rt] into ReadData1/ReadData2 one
// cycle later; rd_valid marks that at least one capture has completed.
// Optional build macro REGFILE_BYPASS_EN: a write on the same edge as a
// read request to the same nonzero address is forwarded into the captured
// operand. Without it the captured operand is the pre-write contents.
module reg_file_reader
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rd_req,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              rd_valid
);

    logic [DATA_W-1:0] arr_rd1;
    logic [DATA_W-1:0] arr_rd2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_d;
    logic              vld_q;
    logic              vld_d;

    regfile_array #(
        .DW(DATA_W),
        .AW(ADDR_W)
    ) u_array (
        .CLK    (CLK),
        .RST    (RST),
        .we     (RegWre),
        .waddr  (WriteReg),
        .wdata  (WriteData),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (arr_rd1),
        .rdata2 (arr_rd2)
    );

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Write-through forwarding; address 0 never forwards so it reads zero.
    always_comb begin
        fwd1 = RegWre && (WriteReg == rs) && (rs != ADDR_W'(ZERO_REG));
        fwd2 = RegWre && (WriteReg == rt) && (rt != ADDR_W'(ZERO_REG));
        val1 = fwd1 ? WriteData : arr_rd1;
        val2 = fwd2 ? WriteData : arr_rd2;
    end
`else
    // No forwarding: operands are the array contents before this edge.
    always_comb begin
        val1 = arr_rd1;
        val2 = arr_rd2;
    end
`endif

    // Operand capture: load on request, otherwise hold; valid is sticky.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        vld_d = vld_q | rd_req;
        if (rd_req) begin
            a_d = val1;
            b_d = val2;
        end
    end

    // A/B operand registers and the valid flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vld_q <= vld_d;
        end
    end

    assign ReadData1 = a_q;
    assign ReadData2 = b_q;
    assign rd_valid  = vld_q;

endmodule : reg_file_reader

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, so each check sees
// what the previous edge captured. Build with +define+REGFILE_BYPASS_EN to
// check the forwarding build.
module tb_reg_file_reader;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RegWre = 1'b0;
    logic [AW-1:0] WriteReg = '0;
    logic [DW-1:0] WriteData = '0;
    logic [AW-1:0] rs = '0;
    logic [AW-1:0] rt = '0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          rd_valid;

    int n_vec = 0;
    int n_err = 0;

    reg_file_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .RegWre    (RegWre),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .rs        (rs),
        .rt        (rt),
        .rd_req    (rd_req),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .rd_valid  (rd_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One clock with the given write and read controls, then idle inputs.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic req, input logic [AW-1:0] a, input logic [AW-1:0] b);
        RegWre = we; WriteReg = wa; WriteData = wd;
        rd_req = req; rs = a; rt = b;
        tick();
        RegWre = 1'b0; rd_req = 1'b0;
    endtask

    logic [DW-1:0] e1, e2;

    initial begin
        // reset state
        #2;
        chk("rst_rd1", ReadData1, '0);
        chk("rst_rd2", ReadData2, '0);
        chk("rst_vld", {31'd0, rd_valid}, 32'd0);
        RST = 1'b1;
        tick();

        // T1: populate, capture, then reset mid-run
        cyc(1'b1, 5'd5, 32'h5555_0005, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9);
        chk("t1_pre_rd1", ReadData1, 32'h5555_0005);
        chk("t1_pre_rd2", ReadData2, 32'h9999_0009);
        chk("t1_pre_vld", {31'd0, rd_valid}, 32'd1);
        RST = 1'b0;
        #1;
        chk("t1_async_rd1", ReadData1, '0);
        chk("t1_async_vld", {31'd0, rd_valid}, 32'd0);
        tick();
        RST = 1'b1;
        tick();
        chk("t1_idle_vld", {31'd0, rd_valid}, 32'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9);
        chk("t1_rd1", ReadData1, '0);
        chk("t1_rd2", ReadData2, '0);
        chk("t1_vld", {31'd0, rd_valid}, 32'd1);

        // T2: write then read
        cyc(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        chk("t2_rd1", ReadData1, 32'hDEAD_BEEF);
        chk("t2_rd2", ReadData2, 32'h0);

        // T3: reg 0 is immutable, including a same-edge read of reg 0
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        chk("t3_same_rd1", ReadData1, 32'h0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3);
        chk("t3_rd1", ReadData1, 32'h0);
        chk("t3_rd2", ReadData2, 32'hDEAD_BEEF);

        // T4: same-edge write and read of reg 7
        cyc(1'b1, 5'd7, 32'hAAAA_0007, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        e1 = 32'h1234_5678;
`else
        e1 = 32'hAAAA_0007;
`endif
        chk("t4_same_rd1", ReadData1, e1);
        chk("t4_same_rd2", ReadData2, e1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3);
        chk("t4_next_rd1", ReadData1, 32'h1234_5678);
        chk("t4_next_rd2", ReadData2, 32'hDEAD_BEEF);

        // T5: hold while reg 3 is rewritten without a request
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 5'd3, 32'hC0DE_0000 + 32'(k), 1'b0, 5'd3, 5'd3);
            chk($sformatf("t5_hold_rd1_%0d", k), ReadData1, 32'h1234_5678);
            chk($sformatf("t5_hold_rd2_%0d", k), ReadData2, 32'hDEAD_BEEF);
        end
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        chk("t5_after_rd1", ReadData1, 32'hC0DE_0003);

        // T6: preload reg[i] = i*4, then stream 32 back-to-back requests
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 5'(i), 32'(i * 4), 1'b0, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            RegWre = 1'b0;
            rd_req = 1'b1;
            rs = 5'(i);
            rt = 5'(31 - i);
            tick();
            e1 = 32'(i * 4);
            e2 = 32'((31 - i) * 4);
            chk($sformatf("t6_rd1_%0d", i), ReadData1, e1);
            chk($sformatf("t6_rd2_%0d", i), ReadData2, e2);
        end
        rd_req = 1'b0;
        tick();
        chk("t6_hold_rd1", ReadData1, 32'd124);
        chk("t6_vld", {31'd0, rd_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end want end");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_file_reader
